// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full-subtractor cell and one borrow flop.
// Define SERIAL_SUB_ADD_MODE_EN to add an op_add input selecting x + y + borrow_in.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             borrow_in,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             op_add,
`endif
    output logic [WIDTH-1:0] d,
    output logic             borrow_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             b_q, b_d;
    logic             borrow_q, borrow_d;
    logic             ov_q, ov_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             add_mode;

`ifdef SERIAL_SUB_ADD_MODE_EN
    logic add_q, add_d;
    assign add_mode = add_q;
`else
    assign add_mode = 1'b0;
`endif

    logic             xi, yi, cell_s, cell_b, ov_next;
    logic [WIDTH-1:0] res_next;

    // Bit cell: full subtractor, or full adder with b acting as carry in add mode.
    always_comb begin
        xi       = x_q[cnt_q];
        yi       = y_q[cnt_q];
        cell_s   = xi ^ yi ^ b_q;
        cell_b   = add_mode ? ((xi & yi) | ((xi ^ yi) & b_q))
                            : ((~xi & yi) | (~(xi ^ yi) & b_q));
        res_next = {cell_s, res_q[WIDTH-1:1]};
        ov_next  = add_mode ? ((x_q[WIDTH-1] == y_q[WIDTH-1]) & (cell_s != x_q[WIDTH-1]))
                            : ((x_q[WIDTH-1] != y_q[WIDTH-1]) & (cell_s != x_q[WIDTH-1]));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        res_d    = res_q;
        d_d      = d_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        ov_d     = ov_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
        add_d    = add_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    b_d     = borrow_in;
`ifdef SERIAL_SUB_ADD_MODE_EN
                    add_d   = op_add;
`endif
                    cnt_d   = '0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                res_d  = res_next;
                b_d    = cell_b;
                cnt_d  = cnt_q + CW'(1);
                busy_d = 1'b1;
                if (cnt_q == LastBit) begin
                    d_d      = res_next;
                    borrow_d = cell_b;
                    ov_d     = ov_next;
                    cnt_d    = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            res_q    <= '0;
            d_q      <= '0;
            b_q      <= 1'b0;
            borrow_q <= 1'b0;
            ov_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            add_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            res_q    <= res_d;
            d_q      <= d_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            ov_q     <= ov_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
            add_q    <= add_d;
`endif
        end
    end

    assign d          = d_q;
    assign borrow_out = borrow_q;
    assign overflow   = ov_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
